// File: rtl/pwm_pkg.sv
// Shared constants for the PWM controller.
// Holds the default counter width and where the period and duty fields sit in the data word.
package pwm_pkg;

  localparam int PWM_ROM_WIDTH  = 8;

  // Field positions in the data word, counted in units of ROM_WIDTH bits.
  localparam int PWM_PER_FIELD  = 1;
  localparam int PWM_DUTY_FIELD = 0;

endpackage

// File: rtl/pwm_if.sv
// Control/waveform bundle between a PWM host and the controller.
// It carries the clock enable, the packed period/duty word and the PWM output.
interface pwm_if
  import pwm_pkg::*;
#(
  parameter int ROM_WIDTH = PWM_ROM_WIDTH
);

  logic                   i_ce;
  logic [2*ROM_WIDTH-1:0] data;
  logic                   PWM_out;

  modport master (
    output i_ce,
    output data,
    input  PWM_out
  );

  modport slave (
    input  i_ce,
    input  data,
    output PWM_out
  );

endinterface

// File: rtl/pwm_counter.sv
// Period counter plus the double-buffered period/duty shadow registers.
// A new period/duty pair is latched from data only on the edge where the counter wraps.
module pwm_counter
  import pwm_pkg::*;
#(
  parameter int ROM_WIDTH = PWM_ROM_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ce_i,
  input  logic [2*ROM_WIDTH-1:0] data_i,
  output logic [ROM_WIDTH-1:0]   cnt_o,
  output logic [ROM_WIDTH-1:0]   per_o,
  output logic [ROM_WIDTH-1:0]   duty_o,
  output logic [ROM_WIDTH-1:0]   cnt_next_o,
  output logic [ROM_WIDTH-1:0]   duty_next_o
);

  logic [ROM_WIDTH-1:0] cnt_q,  cnt_d;
  logic [ROM_WIDTH-1:0] per_q,  per_d;
  logic [ROM_WIDTH-1:0] duty_q, duty_d;

  always_comb begin
    cnt_d  = cnt_q;
    per_d  = per_q;
    duty_d = duty_q;
    if (ce_i) begin
      // cnt never exceeds per_q, so the all-ones period wraps before overflow.
      if (cnt_q >= per_q) begin
        cnt_d  = '0;
        per_d  = data_i[PWM_PER_FIELD*ROM_WIDTH  +: ROM_WIDTH];
        duty_d = data_i[PWM_DUTY_FIELD*ROM_WIDTH +: ROM_WIDTH];
      end else begin
        cnt_d  = cnt_q + ROM_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      per_q  <= '0;
      duty_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      per_q  <= per_d;
      duty_q <= duty_d;
    end
  end

  assign cnt_o       = cnt_q;
  assign per_o       = per_q;
  assign duty_o      = duty_q;
  assign cnt_next_o  = cnt_d;
  assign duty_next_o = duty_d;

endmodule

// File: rtl/pwm_controller.sv
// PWM generator: counter/shadow sub-module plus the duty comparator and output flop.
// The comparator looks at next-state values so PWM_out equals (cnt < duty_a) with no lag.
module pwm_controller
  import pwm_pkg::*;
#(
  parameter int ROM_WIDTH = PWM_ROM_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  pwm_if.slave bus
);

  logic [ROM_WIDTH-1:0] cnt;
  logic [ROM_WIDTH-1:0] per_a;
  logic [ROM_WIDTH-1:0] duty_a;
  logic [ROM_WIDTH-1:0] cnt_next;
  logic [ROM_WIDTH-1:0] duty_next;
  logic                 out_q, out_d;

  pwm_counter #(
    .ROM_WIDTH (ROM_WIDTH)
  ) u_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .ce_i        (bus.i_ce),
    .data_i      (bus.data),
    .cnt_o       (cnt),
    .per_o       (per_a),
    .duty_o      (duty_a),
    .cnt_next_o  (cnt_next),
    .duty_next_o (duty_next)
  );

  always_comb begin
    out_d = out_q;
    if (bus.i_ce) begin
      out_d = (cnt_next < duty_next);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= 1'b0;
    end else begin
      out_q <= out_d;
    end
  end

  assign bus.PWM_out = out_q;

endmodule

// File: tb/tb_pwm_controller.sv
// Self-checking bench for pwm_controller: directed scenarios plus randomized traffic.
// The reference tracks the position inside the current period and its latched length/high time.
module tb_pwm_controller;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference: position in period, period length and high time of the period in progress.
  int m_pos;
  int m_plen;
  int m_hlen;

  pwm_if #(.ROM_WIDTH(W)) bus ();

  pwm_controller #(.ROM_WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pos  = 0;
    m_plen = 1;
    m_hlen = 0;
  endfunction

  function automatic void model_edge(input logic [2*W-1:0] d);
    int per_v;
    int duty_v;
    m_pos++;
    if (m_pos >= m_plen) begin
      per_v  = int'(d[2*W-1:W]);
      duty_v = int'(d[W-1:0]);
      m_pos  = 0;
      m_plen = per_v + 1;
      m_hlen = (duty_v < m_plen) ? duty_v : m_plen;
    end
  endfunction

  function automatic int model_out();
    return (m_pos < m_hlen) ? 1 : 0;
  endfunction

  task automatic step(input logic ce, input logic [2*W-1:0] d);
    @(negedge clk);
    bus.i_ce = ce;
    bus.data = d;
    @(posedge clk);
    if (rst_n && ce) model_edge(d);
    #1;
    check_val("pwm", int'(bus.PWM_out), model_out());
    check_val("cnt", int'(dut.u_counter.cnt_q), m_pos);
  endtask

  task automatic run_ones(input int n, input logic [2*W-1:0] d, input int ce_every,
                          output int ones);
    ones = 0;
    for (int i = 0; i < n; i++) begin
      step((ce_every > 0) && (i % ce_every == 0), d);
      ones += int'(bus.PWM_out);
    end
  endtask

  // Asynchronous reset in the middle of a clock phase; released before the next step.
  task automatic pulse_reset();
    @(negedge clk);
    bus.i_ce = 1'b1;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_val("rst_async_pwm", int'(bus.PWM_out), model_out());
    check_val("rst_async_cnt", int'(dut.u_counter.cnt_q), m_pos);
    @(posedge clk);
    #1;
    check_val("rst_hold_pwm", int'(bus.PWM_out), 0);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    int ones;
    logic [2*W-1:0] bnd [4];
    int bnd_ones [4];
    logic [2*W-1:0] rdata;

    model_reset();
    bus.i_ce = 1'b0;
    bus.data = 16'h0A04;

    // Held reset with toggling enable.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.i_ce = i[0];
      bus.data = 16'h0A04;
      @(posedge clk);
      #1;
      check_val("reset_pwm", int'(bus.PWM_out), 0);
      check_val("reset_cnt", int'(dut.u_counter.cnt_q), 0);
    end
    #3;
    rst_n = 1'b1;

    // Nominal 3 high / 7 low.
    run_ones(10, 16'h0903, 1, ones);
    check_val("nominal_first_period", ones, 3);
    run_ones(20, 16'h0903, 1, ones);
    check_val("nominal_two_periods", ones, 6);

    // New data mid-period only takes effect at the next wrap.
    run_ones(4, 16'h0903, 1, ones);
    check_val("dbuf_head", ones, 3);
    run_ones(6, 16'h0405, 1, ones);
    check_val("dbuf_tail_old", ones, 0);
    run_ones(10, 16'h0405, 1, ones);
    check_val("dbuf_new", ones, 10);

    // Boundaries: settle one full period, then measure a window.
    bnd[0] = 16'h0900; bnd_ones[0] = 0;
    bnd[1] = 16'h0410; bnd_ones[1] = 50;
    bnd[2] = 16'hFFFF; bnd_ones[2] = 255;
    bnd[3] = 16'h0001; bnd_ones[3] = 50;
    for (int b = 0; b < 4; b++) begin
      run_ones(300, bnd[b], 1, ones);
      run_ones((b == 2) ? 256 : 50, bnd[b], 1, ones);
      check_val($sformatf("boundary_%04h", bnd[b]), ones, bnd_ones[b]);
    end

    // Enable every 4th clock stretches the 3/7 pattern by 4.
    pulse_reset();
    run_ones(160, 16'h0903, 4, ones);
    check_val("ce_div4", ones, 48);
    run_ones(8, 16'h0903, 4, ones);
    check_val("ce_div4_next", ones, 8);
    run_ones(20, 16'h0903, 0, ones);
    check_val("ce_frozen", ones, 20);

    // Reset while the output is high, at cnt=5.
    pulse_reset();
    run_ones(6, 16'h0907, 1, ones);
    check_val("pre_reset_ones", ones, 6);
    check_val("pre_reset_cnt", int'(dut.u_counter.cnt_q), 5);
    pulse_reset();
    step(1'b1, 16'h0907);
    check_val("post_reset_cnt", int'(dut.u_counter.cnt_q), 0);
    run_ones(9, 16'h0907, 1, ones);
    check_val("post_reset_period", ones + int'(1), 7);

    // Randomized traffic with occasional async resets.
    rdata = 16'h0302;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 9) == 0)
          rdata = 16'($urandom);
        else
          rdata = {8'($urandom_range(0, 12)), 8'($urandom_range(0, 15))};
      end
      if ($urandom_range(0, 199) == 0) pulse_reset();
      step($urandom_range(0, 3) != 0, rdata);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
